sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_scan.sv | 128 ++++++++++++
 tb/tb_sevenseg_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - multiplexed 7-segment scanner with frame-synchronous shadow data
// Optional leading-zero blanking: define SEVENSEG_LZB_EN.
module sevenseg_scan #(
  parameter int NDIGITS = 3,
  parameter int DIV     = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   blank,
  output logic [7:0]             segments,
  output logic [NDIGITS-1:0]     digs,
  output logic                   frame
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [15:0]            count;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_next;
  logic                   tick;
  logic                   frame_start;
  logic                   blank_q;
  logic                   update;
  logic [4*NDIGITS-1:0]   shadow_data;
  logic [NDIGITS-1:0]     shadow_dp;
  logic [4*NDIGITS-1:0]   src_data;
  logic [NDIGITS-1:0]     src_dp;
  logic [7:0]             seg_next;
  logic [NDIGITS-1:0]     digs_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick = (count == 16'(DIV - 1));
    idx_next = idx;
    if (tick) begin
      idx_next = (idx == IW'(NDIGITS - 1)) ? '0 : idx + 1'b1;
    end
    frame_start = tick && (idx_next == '0);
    // Digit 0 of a new frame must show the value being captured on this same edge.
    src_data = frame_start ? data : shadow_data;
    src_dp   = frame_start ? dp   : shadow_dp;
    // Blank is re-evaluated every clock, and the cycle after it drops restores the digit.
    update   = tick || blank || blank_q;
  end

`ifdef SEVENSEG_LZB_EN
  logic [NDIGITS-1:0] lead_zero;

  always_comb begin : lzb_scan
    logic zero_run;
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (src_data[4*k +: 4] == 4'h0);
      lead_zero[k] = zero_run;
    end
  end
`endif

  always_comb begin
    digs_next = '0;
    seg_next  = 8'hFF;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_next == IW'(k)) begin
        digs_next[k] = 1'b1;
        seg_next     = {~src_dp[k], hex7(src_data[4*k +: 4])};
`ifdef SEVENSEG_LZB_EN
        if (k > 0 && lead_zero[k]) begin
          seg_next[6:0] = 7'h7F;
        end
`endif
      end
    end
    if (blank) begin
      digs_next = '0;
      seg_next  = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      idx         <= '0;
      digs        <= NDIGITS'(1);
      segments    <= 8'hFF;
      frame       <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      blank_q     <= 1'b0;
    end else begin
      count   <= tick ? 16'd0 : count + 16'd1;
      idx     <= idx_next;
      frame   <= frame_start;
      blank_q <= blank;
      if (frame_start) begin
        shadow_data <= data;
        shadow_dp   <= dp;
      end
      if (update) begin
        digs     <= digs_next;
        segments <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - directed self-checking bench for sevenseg_scan
module tb_sevenseg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, blank_a, frame_a;
  logic [11:0] data_a;
  logic [2:0]  dp_a, digs_a;
  logic [7:0]  seg_a;

  logic        rst_b, blank_b, frame_b, dp_b, digs_b;
  logic [3:0]  data_b;
  logic [7:0]  seg_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  sevenseg_scan #(.NDIGITS(3), .DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .data(data_a), .dp(dp_a), .blank(blank_a),
    .segments(seg_a), .digs(digs_a), .frame(frame_a)
  );

  sevenseg_scan #(.NDIGITS(1), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .data(data_b), .dp(dp_b), .blank(blank_b),
    .segments(seg_b), .digs(digs_b), .frame(frame_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    data_a = 12'h000; dp_a = 3'b000; blank_a = 1'b0;
    rst_a = 1'b0;
    step();
    checks++; if (digs_a !== 3'b001) begin errors++; $display("FAIL reset_digs: got %b want 001", digs_a); end
    checks++; if (seg_a !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg_a); end
    checks++; if (frame_a !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", frame_a); end
    rst_a = 1'b1;
    cyc = 0;
  endtask

  task automatic test_scan();
    logic [2:0] ed;
    logic [7:0] es;
    for (int c = 1; c <= 13; c++) begin
      step();
      ed = (c < 4) ? 3'b001 : (c < 8) ? 3'b010 : (c < 12) ? 3'b100 : 3'b001;
      es = (c < 4) ? 8'hFF : 8'hC0;
      checks++; if (digs_a !== ed) begin errors++; $display("FAIL scan_digs c=%0d: got %b want %b", c, digs_a, ed); end
      checks++; if (seg_a !== es) begin errors++; $display("FAIL scan_seg c=%0d: got %h want %h", c, seg_a, es); end
      checks++; if (frame_a !== (c == 12)) begin errors++; $display("FAIL scan_frame c=%0d: got %b want %b", c, frame_a, (c == 12)); end
    end
  endtask

  task automatic test_shadow();
    data_a = 12'h123; dp_a = 3'b000;
    reset_a();
    run_to(12);
    checks++; if (seg_a !== 8'hB0 || digs_a !== 3'b001 || frame_a !== 1'b1) begin errors++; $display("FAIL shadow_d0: got %h/%b/%b want b0/001/1", seg_a, digs_a, frame_a); end
    data_a = 12'h456;
    run_to(14);
    checks++; if (seg_a !== 8'hB0) begin errors++; $display("FAIL shadow_hold: got %h want b0", seg_a); end
    run_to(16);
    checks++; if (seg_a !== 8'hA4) begin errors++; $display("FAIL shadow_d1: got %h want a4", seg_a); end
    run_to(20);
    checks++; if (seg_a !== 8'hF9) begin errors++; $display("FAIL shadow_d2: got %h want f9", seg_a); end
    run_to(24);
    checks++; if (seg_a !== 8'h82 || frame_a !== 1'b1) begin errors++; $display("FAIL shadow_new_d0: got %h/%b want 82/1", seg_a, frame_a); end
    run_to(28);
    checks++; if (seg_a !== 8'h92) begin errors++; $display("FAIL shadow_new_d1: got %h want 92", seg_a); end
    run_to(32);
    checks++; if (seg_a !== 8'h99) begin errors++; $display("FAIL shadow_new_d2: got %h want 99", seg_a); end
  endtask

  task automatic test_decode_dp();
    logic [7:0] exp_seg;
    rst_b = 1'b0; blank_b = 1'b0; data_b = 4'h0; dp_b = 1'b0;
    step();
    checks++; if (seg_b !== 8'hFF || digs_b !== 1'b1 || frame_b !== 1'b0) begin errors++; $display("FAIL decode_reset: got %h/%b/%b want ff/1/0", seg_b, digs_b, frame_b); end
    rst_b = 1'b1;
    dp_b = 1'b1;
    for (int n = 0; n < 16; n++) begin
      data_b = 4'(n);
      step();
      exp_seg = codes[n] & 8'h7F;
      checks++; if (seg_b !== exp_seg || frame_b !== 1'b1) begin errors++; $display("FAIL decode_%0h: got %h/%b want %h/1", n, seg_b, frame_b, exp_seg); end
    end
    rst_b = 1'b0;
  endtask

  task automatic test_blank();
    data_a = 12'h123; dp_a = 3'b000; blank_a = 1'b0;
    reset_a();
    run_to(13);
    checks++; if (seg_a !== 8'hB0 || digs_a !== 3'b001) begin errors++; $display("FAIL blank_pre: got %h/%b want b0/001", seg_a, digs_a); end
    blank_a = 1'b1;
    for (int c = 14; c <= 16; c++) begin
      step();
      checks++; if (digs_a !== 3'b000 || seg_a !== 8'hFF || frame_a !== 1'b0) begin errors++; $display("FAIL blank_on c=%0d: got %b/%h/%b want 000/ff/0", c, digs_a, seg_a, frame_a); end
    end
    blank_a = 1'b0;
    step();
    checks++; if (digs_a !== 3'b010 || seg_a !== 8'hA4) begin errors++; $display("FAIL blank_restore: got %b/%h want 010/a4", digs_a, seg_a); end
    run_to(20);
    checks++; if (digs_a !== 3'b100 || seg_a !== 8'hF9) begin errors++; $display("FAIL blank_next_tick: got %b/%h want 100/f9", digs_a, seg_a); end
    run_to(23);
    checks++; if (digs_a !== 3'b100 || frame_a !== 1'b0) begin errors++; $display("FAIL blank_hold: got %b/%b want 100/0", digs_a, frame_a); end
    run_to(24);
    checks++; if (digs_a !== 3'b001 || frame_a !== 1'b1) begin errors++; $display("FAIL blank_frame: got %b/%b want 001/1", digs_a, frame_a); end
  endtask

  task automatic test_lzb();
    logic [7:0] e1, e2;
`ifdef SEVENSEG_LZB_EN
    e1 = 8'h7F; e2 = 8'hFF;
`else
    e1 = 8'h40; e2 = 8'hC0;
`endif
    data_a = 12'h005; dp_a = 3'b010;
    reset_a();
    run_to(12);
    checks++; if (seg_a !== 8'h92) begin errors++; $display("FAIL lzb_d0: got %h want 92", seg_a); end
    run_to(16);
    checks++; if (seg_a !== e1) begin errors++; $display("FAIL lzb_d1: got %h want %h", seg_a, e1); end
    run_to(20);
    checks++; if (seg_a !== e2) begin errors++; $display("FAIL lzb_d2: got %h want %h", seg_a, e2); end
  endtask

  task automatic test_midrun_reset();
    data_a = 12'h123; dp_a = 3'b000;
    reset_a();
    run_to(21);
    checks++; if (digs_a !== 3'b100) begin errors++; $display("FAIL midrst_pre: got %b want 100", digs_a); end
    rst_a = 1'b0;
    step();
    checks++; if (digs_a !== 3'b001 || seg_a !== 8'hFF || frame_a !== 1'b0) begin errors++; $display("FAIL midrst_edge: got %b/%h/%b want 001/ff/0", digs_a, seg_a, frame_a); end
    rst_a = 1'b1;
    cyc = 0;
    run_to(3);
    checks++; if (digs_a !== 3'b001 || seg_a !== 8'hFF) begin errors++; $display("FAIL midrst_slot: got %b/%h want 001/ff", digs_a, seg_a); end
    run_to(4);
    checks++; if (digs_a !== 3'b010 || seg_a !== 8'hC0) begin errors++; $display("FAIL midrst_shadow: got %b/%h want 010/c0", digs_a, seg_a); end
  endtask

  initial begin
    rst_a = 1'b0; blank_a = 1'b0; data_a = '0; dp_a = '0;
    rst_b = 1'b0; blank_b = 1'b0; data_b = '0; dp_b = 1'b0;
    #2;
    test_reset();
    test_scan();
    test_shadow();
    test_decode_dp();
    test_blank();
    test_lzb();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
